// File: rtl/spi_word_receiver_if.sv
// Bus bundle for spi_word_receiver: SPI pins in, assembled words out through a valid/ready FIFO head.
// slave = receiver side, master = SPI driver / word consumer side.
`timescale 1ns/1ps
interface spi_word_receiver_if #(
  parameter int WORD_BYTES = 6,
  parameter int FIFO_DEPTH = 4
);
  localparam int DW = 8 * WORD_BYTES;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          CS;
  logic          SCK;
  logic          MOSI;
  logic          word_valid;
  logic          word_ready;
  logic [DW-1:0] word_data;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          frame_err;

  modport slave (
    input  CS, SCK, MOSI, word_ready,
    output word_valid, word_data, fifo_level, overflow, frame_err
  );

  modport master (
    output CS, SCK, MOSI, word_ready,
    input  word_valid, word_data, fifo_level, overflow, frame_err
  );
endinterface

// File: rtl/spi_word_receiver.sv
// SPI slave receive path: oversampled pins -> byte/word assembly -> word FIFO with registered head.
// Optional sim-only push/overflow trace is enabled by defining SPI_RX_DISPLAY_EN.
`timescale 1ns/1ps
module spi_word_receiver #(
  parameter int WORD_BYTES    = 6,
  parameter int CPOL          = 0,
  parameter int CPHA          = 0,
  parameter int BIT_MSB_FIRST = 1,
  parameter int BYTE_LE       = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic               iclk,
  input  logic               rstn,
  spi_word_receiver_if.slave bus
);
  localparam int DW = 8 * WORD_BYTES;
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  logic [1:0]    cs_sync_q, sck_sync_q, mosi_sync_q;
  logic          cs_prev_q, sck_prev_q;
  logic          cs_s, sck_s, mosi_s, cs_rise_s, cs_fall_s, sample_edge_s;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] byte_idx_q, byte_idx_d, slot_s;
  logic [7:0]    shift_q, shift_d, byte_s;
  logic [DW-1:0] asm_q, asm_d;
  logic          push_q, push_d;
  logic [DW-1:0] push_word_q, push_word_d;
  logic          ferr_q, ferr_d;

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          valid_q, valid_d, ovf_q, ovf_d;
  logic [DW-1:0] data_q, data_d;
  logic          pop_s, full_s, push_ok_s;

  // CS synchroniser resets low so a CS already low at reset release is not mistaken for a frame start.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      cs_sync_q   <= 2'b00;
      sck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_prev_q   <= 1'b0;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], bus.CS};
      sck_sync_q  <= {sck_sync_q[0], bus.SCK};
      mosi_sync_q <= {mosi_sync_q[0], bus.MOSI};
      cs_prev_q   <= cs_sync_q[1];
      sck_prev_q  <= sck_sync_q[1];
    end
  end

  assign cs_s          = cs_sync_q[1];
  assign sck_s         = sck_sync_q[1];
  assign mosi_s        = mosi_sync_q[1];
  assign cs_rise_s     = cs_s & ~cs_prev_q;
  assign cs_fall_s     = ~cs_s & cs_prev_q;
  assign sample_edge_s = (CPOL == CPHA) ? (sck_s & ~sck_prev_q) : (~sck_s & sck_prev_q);
  assign slot_s        = (BYTE_LE != 0) ? byte_idx_q : (IW'(WORD_BYTES - 1) - byte_idx_q);
  assign byte_s        = (BIT_MSB_FIRST != 0) ? {shift_q[6:0], mosi_s} : {mosi_s, shift_q[7:1]};

  // Frame FSM and byte/word assembly; ST_IDLE waits for a clean CS falling edge.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    asm_d       = asm_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    ferr_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d  = 3'd0;
        byte_idx_d = {IW{1'b0}};
        shift_d    = 8'h00;
        asm_d      = {DW{1'b0}};
        if (cs_fall_s) state_d = ST_ACTIVE;
        else           state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (cs_rise_s) begin
          state_d    = ST_IDLE;
          ferr_d     = (bit_cnt_q != 3'd0) || (byte_idx_q != {IW{1'b0}});
          bit_cnt_d  = 3'd0;
          byte_idx_d = {IW{1'b0}};
          shift_d    = 8'h00;
          asm_d      = {DW{1'b0}};
        end else if (sample_edge_s && !cs_s) begin
          shift_d = byte_s;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            for (int k = 0; k < WORD_BYTES; k++) begin
              if (slot_s == IW'(k)) asm_d[8*k +: 8] = byte_s;
              else                  asm_d[8*k +: 8] = asm_q[8*k +: 8];
            end
            if (byte_idx_q == IW'(WORD_BYTES - 1)) begin
              byte_idx_d  = {IW{1'b0}};
              push_d      = 1'b1;
              push_word_d = asm_d;
            end else begin
              byte_idx_d = byte_idx_q + IW'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Receive-side state registers.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_idx_q  <= {IW{1'b0}};
      shift_q     <= 8'h00;
      asm_q       <= {DW{1'b0}};
      push_q      <= 1'b0;
      push_word_q <= {DW{1'b0}};
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      asm_q       <= asm_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      ferr_q      <= ferr_d;
    end
  end

  assign pop_s     = valid_q & bus.word_ready;
  assign full_s    = (level_q == LW'(FIFO_DEPTH));
  assign push_ok_s = push_q & (~full_s | pop_s);

  // FIFO bookkeeping; the head is pre-computed so word_data can be a register.
  always_comb begin
    wr_ptr_d = push_ok_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    ovf_d    = push_q & full_s & ~pop_s;
    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    valid_d = (level_d != {LW{1'b0}});
    if (level_d == {LW{1'b0}})                    data_d = data_q;
    else if (push_ok_s && (wr_ptr_q == rd_ptr_d)) data_d = push_word_q;
    else                                          data_d = mem_q[rd_ptr_d];
  end

  // FIFO storage, pointers and registered outputs.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= {DW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      level_q  <= {LW{1'b0}};
      valid_q  <= 1'b0;
      data_q   <= {DW{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok_s) mem_q[wr_ptr_q] <= push_word_q;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.word_valid = valid_q;
  assign bus.word_data  = data_q;
  assign bus.fifo_level = level_q;
  assign bus.overflow   = ovf_q;
  assign bus.frame_err  = ferr_q;

`ifdef SPI_RX_DISPLAY_EN
  // Simulation trace of accepted and dropped words.
  always_ff @(posedge iclk) begin
    if (push_ok_s)  $display("%0t spi_rx word=%h", $time, push_word_q);
    else if (ovf_d) $display("spi_rx OVERFLOW %h", push_word_q);
  end
`else
  // No trace in the default build.
`endif
endmodule

// File: tb/tb_spi_word_receiver.sv
// Scoreboard bench: DUT A = mode 0 / MSB-first / little-endian 6-byte words, DUT B = mode 3 / LSB-first / big-endian 2-byte words.
`timescale 1ns/1ps
module tb_spi_word_receiver;
  localparam int WB_A  = 6;
  localparam int WB_B  = 2;
  localparam int DEPTH = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spi_word_receiver_if #(.WORD_BYTES(WB_A), .FIFO_DEPTH(DEPTH)) bus_a ();
  spi_word_receiver_if #(.WORD_BYTES(WB_B), .FIFO_DEPTH(DEPTH)) bus_b ();

  spi_word_receiver #(.WORD_BYTES(WB_A), .CPOL(0), .CPHA(0), .BIT_MSB_FIRST(1), .BYTE_LE(1),
                      .FIFO_DEPTH(DEPTH)) u_a (.iclk(clk), .rstn(rstn), .bus(bus_a));
  spi_word_receiver #(.WORD_BYTES(WB_B), .CPOL(1), .CPHA(1), .BIT_MSB_FIRST(0), .BYTE_LE(0),
                      .FIFO_DEPTH(DEPTH)) u_b (.iclk(clk), .rstn(rstn), .bus(bus_b));

  int n_cmp = 0;
  int n_bad = 0;
  logic [47:0] exp_a [$];
  logic [15:0] exp_b [$];
  int ovf_seen_a = 0, ferr_seen_a = 0, ovf_seen_b = 0, ferr_seen_b = 0;
  int ready_mode_a = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [47:0] rand48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Consumer handshake for DUT A: 0 = hold off, 1 = always ready, 2 = random.
  initial begin
    bus_a.word_ready = 1'b0;
    bus_b.word_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode_a)
        0:       bus_a.word_ready = 1'b0;
        1:       bus_a.word_ready = 1'b1;
        default: bus_a.word_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitors: pop the expected word on every accepted handshake, count status pulses.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus_a.word_valid && bus_a.word_ready) begin
        if (exp_a.size() == 0) check("a_unexpected_word", {16'h0, bus_a.word_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        else                   check("a_word", {16'h0, bus_a.word_data}, {16'h0, exp_a.pop_front()});
      end
      if (bus_a.overflow)  ovf_seen_a++;
      if (bus_a.frame_err) ferr_seen_a++;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (bus_b.word_valid && bus_b.word_ready) begin
        if (exp_b.size() == 0) check("b_unexpected_word", {48'h0, bus_b.word_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        else                   check("b_word", {48'h0, bus_b.word_data}, {48'h0, exp_b.pop_front()});
      end
      if (bus_b.overflow)  ovf_seen_b++;
      if (bus_b.frame_err) ferr_seen_b++;
    end
  end

  // mode: 0 plain bit, 1 measure word_valid latency, 2 pop exactly when the word lands.
  task automatic bit_a(input logic b, input int mode);
    int lat;
    bus_a.MOSI = b;
    wait_clk(4);
    bus_a.SCK = 1'b1;
    if (mode == 1) begin
      lat = 0;
      while (!bus_a.word_valid && lat < 8) begin
        wait_clk(1);
        lat++;
      end
      check("t1_valid_within_4", {63'h0, (bus_a.word_valid && lat <= 4)}, 64'h1);
    end else if (mode == 2) begin
      wait_clk(3);
      ready_mode_a = 1;
      wait_clk(1);
      ready_mode_a = 0;
      check("t5_level_push_pop", {61'h0, bus_a.fifo_level}, 64'd4);
    end else begin
      wait_clk(4);
    end
    bus_a.SCK = 1'b0;
  endtask

  task automatic byte_a(input logic [7:0] v, input int last_mode);
    for (int i = 7; i >= 0; i--) bit_a(v[i], (i == 0) ? last_mode : 0);
  endtask

  // Byte k travels first-to-last and lands in word[8k+7:8k].
  task automatic word_a(input logic [47:0] w, input bit store, input int last_mode);
    if (store) exp_a.push_back(w);
    for (int k = 0; k < WB_A; k++) byte_a(w[8*k +: 8], (k == WB_A - 1) ? last_mode : 0);
  endtask

  task automatic cs_low_a();
    bus_a.CS = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high_a();
    wait_clk(4);
    bus_a.CS = 1'b1;
    wait_clk(8);
  endtask

  task automatic bit_b(input logic b);
    bus_b.SCK  = 1'b0;
    bus_b.MOSI = b;
    wait_clk(4);
    bus_b.SCK = 1'b1;
    wait_clk(4);
  endtask

  // LSB-first bits; first byte lands in the top byte of the word.
  task automatic word_b(input logic [15:0] w);
    exp_b.push_back(w);
    for (int k = 0; k < WB_B; k++)
      for (int i = 0; i < 8; i++) bit_b(w[8*(WB_B-1-k) + i]);
  endtask

  task automatic frame_b(input int nwords);
    bus_b.CS = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nwords; i++) word_b(16'($urandom()));
    wait_clk(4);
    bus_b.CS = 1'b1;
    wait_clk(8);
  endtask

  task automatic drain_a(input string name);
    int t;
    ready_mode_a = 1;
    t = 0;
    while (exp_a.size() != 0 && t < 300) begin
      wait_clk(1);
      t++;
    end
    check(name, 64'(exp_a.size()), 64'd0);
    wait_clk(3);
    check({name, "_level0"}, {61'h0, bus_a.fifo_level}, 64'd0);
  endtask

  initial begin
    logic [47:0] w5 [5];
    bus_a.CS = 1'b1; bus_a.SCK = 1'b0; bus_a.MOSI = 1'b0;
    bus_b.CS = 1'b1; bus_b.SCK = 1'b1; bus_b.MOSI = 1'b0;
    wait_clk(3);
    check("rst_a_valid", {63'h0, bus_a.word_valid}, 64'h0);
    check("rst_a_level", {61'h0, bus_a.fifo_level}, 64'h0);
    check("rst_a_data",  {16'h0, bus_a.word_data}, 64'h0);
    check("rst_a_pulses", {62'h0, bus_a.overflow, bus_a.frame_err}, 64'h0);
    check("rst_b_valid", {63'h0, bus_b.word_valid}, 64'h0);
    rstn = 1'b1;
    wait_clk(5);

    // One frame, bytes 01..06, latency measured on the last bit.
    ready_mode_a = 0;
    cs_low_a();
    word_a(48'h0605_0403_0201, 1'b1, 1);
    cs_high_a();
    check("t1_head", {16'h0, bus_a.word_data}, 64'h0000_0605_0403_0201);
    check("t1_frame_err", 64'(ferr_seen_a), 64'd0);
    drain_a("t1_drain");

    // Mode 3, LSB first, big-endian bytes, then random frames.
    bus_b.CS = 1'b0;
    wait_clk(4);
    word_b(16'hA53C);
    wait_clk(4);
    bus_b.CS = 1'b1;
    wait_clk(8);
    check("t2_a53c_seen", 64'(exp_b.size()), 64'd0);
    for (int f = 0; f < 3; f++) frame_b($urandom_range(1, 3));
    check("t2_b_drained", 64'(exp_b.size()), 64'd0);
    check("t2_b_no_err", 64'(ferr_seen_b + ovf_seen_b), 64'd0);

    // Abort after 3 bytes + 4 bits, then a good frame.
    cs_low_a();
    for (int i = 0; i < 3; i++) byte_a(8'($urandom()), 0);
    for (int i = 0; i < 4; i++) bit_a(1'($urandom_range(0, 1)), 0);
    cs_high_a();
    check("t3_frame_err", 64'(ferr_seen_a), 64'd1);
    check("t3_no_push", {61'h0, bus_a.fifo_level}, 64'd0);
    cs_low_a();
    word_a(rand48(), 1'b1, 0);
    cs_high_a();
    drain_a("t3_drain");
    check("t3_single_err", 64'(ferr_seen_a), 64'd1);

    // Five words into a depth-4 FIFO with no consumer.
    ready_mode_a = 0;
    cs_low_a();
    for (int i = 0; i < 5; i++) word_a(rand48(), i < 4, 0);
    cs_high_a();
    check("t4_level_full", {61'h0, bus_a.fifo_level}, 64'd4);
    check("t4_overflow", 64'(ovf_seen_a), 64'd1);
    drain_a("t4_drain");

    // Full FIFO, fifth word lands on the same cycle as a pop.
    ready_mode_a = 0;
    for (int i = 0; i < 5; i++) w5[i] = rand48();
    cs_low_a();
    for (int i = 0; i < 4; i++) word_a(w5[i], 1'b1, 0);
    word_a(w5[4], 1'b1, 2);
    cs_high_a();
    check("t5_no_overflow", 64'(ovf_seen_a), 64'd1);
    check("t5_level", {61'h0, bus_a.fifo_level}, 64'd4);
    drain_a("t5_drain");

    // Random consumer, random words per frame.
    ready_mode_a = 2;
    for (int f = 0; f < 3; f++) begin
      cs_low_a();
      for (int i = 0; i < int'($urandom_range(1, 2)); i++) word_a(rand48(), 1'b1, 0);
      cs_high_a();
    end
    drain_a("rand_drain");
    check("rand_no_overflow", 64'(ovf_seen_a), 64'd1);

    // Reset mid-byte, bits with CS still low are ignored, next frame works.
    ready_mode_a = 0;
    cs_low_a();
    word_a(rand48(), 1'b0, 0);
    wait_clk(6);
    check("t6_level_before", {61'h0, bus_a.fifo_level}, 64'd1);
    for (int i = 0; i < 4; i++) bit_a(1'($urandom_range(0, 1)), 0);
    rstn = 1'b0;
    #1;
    check("t6_rst_valid", {63'h0, bus_a.word_valid}, 64'h0);
    check("t6_rst_level", {61'h0, bus_a.fifo_level}, 64'h0);
    check("t6_rst_data",  {16'h0, bus_a.word_data}, 64'h0);
    wait_clk(2);
    rstn = 1'b1;
    wait_clk(4);
    word_a(rand48(), 1'b0, 0);
    wait_clk(8);
    check("t6_ignored_level", {61'h0, bus_a.fifo_level}, 64'd0);
    cs_high_a();
    check("t6_no_frame_err", 64'(ferr_seen_a), 64'd1);
    cs_low_a();
    word_a(rand48(), 1'b1, 0);
    cs_high_a();
    drain_a("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    n_bad++;
    $display("FAIL timeout: bench did not complete, compared=%0d", n_cmp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "time limit reached");
  end
endmodule
